fsm_serial_tx: RTL

FSM_SERIAL_TX -- requirements
Module: fsm_serial_tx

---
 rtl/fsm_tx_pkg.sv | 25 ++
 rtl/fsm_serial_tx_if.sv | 33 +++
 rtl/fsm_serial_tx_props.sv | 50 +++++
 rtl/fsm_tx_counter.sv | 36 +++
 rtl/fsm_serial_tx.sv | 94 +++++++++
 5 files changed

// File: rtl/fsm_tx_pkg.sv
// ---------------------------------------------------------------------------
// fsm_tx_pkg : shared state encoding and default constants for the serial TX
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fsm_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_e;

  localparam int c_width_def      = 8;
  localparam int c_gap_cycles_def = 1;

  // One counter serves both bit and gap counting, so it must reach WIDTH-1 and 15.
  function automatic int cnt_width(input int width);
    return (width > 16) ? $clog2(width) : 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fsm_serial_tx_if.sv
// ---------------------------------------------------------------------------
// fsm_serial_tx_if : word-in / bit-out handshake bundle of the serial TX
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fsm_serial_tx_if
  import fsm_tx_pkg::*;
#(
  parameter int WIDTH = c_width_def
) ();

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output data_in, data_valid,
    input  data_ready, dout, dout_valid, busy, done
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, dout, dout_valid, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/fsm_serial_tx_props.sv
// ---------------------------------------------------------------------------
// fsm_serial_tx_props : handshake, done, idle-output and reset properties
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifdef FORMAL
module fsm_serial_tx_props
  import fsm_tx_pkg::*;
(
  input logic      clk,
  input logic      rst,
  input tx_state_e state_q,
  input logic      cnt_tc,
  input logic      data_ready,
  input logic      dout,
  input logic      dout_valid,
  input logic      busy,
  input logic      done
);

  always_comb begin
    if (!rst) begin
      a_reset: assert (data_ready && !dout && !dout_valid && !done && !busy);
    end
  end

  a_ready_idle: assert property (@(posedge clk) disable iff (!rst)
    data_ready == (state_q == ST_IDLE));
  a_done_last: assert property (@(posedge clk) disable iff (!rst)
    done == ((state_q == ST_SHIFT) && cnt_tc));
  a_dout_quiet: assert property (@(posedge clk) disable iff (!rst)
    !dout_valid |-> !dout);

endmodule

bind fsm_serial_tx fsm_serial_tx_props u_props (
  .clk        (clk),
  .rst        (rst),
  .state_q    (state_q),
  .cnt_tc     (cnt_tc),
  .data_ready (bus.data_ready),
  .dout       (bus.dout),
  .dout_valid (bus.dout_valid),
  .busy       (bus.busy),
  .done       (bus.done)
);
`endif

`default_nettype wire

// File: rtl/fsm_tx_counter.sv
// ---------------------------------------------------------------------------
// fsm_tx_counter : up-counter with clear-load, enable and terminal-count flag
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fsm_tx_counter
  import fsm_tx_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc_o = (count_q == last_i);

endmodule

`default_nettype wire

// File: rtl/fsm_serial_tx.sv
// ---------------------------------------------------------------------------
// fsm_serial_tx : parallel word to MSB-first serial stream with inter-word gap
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fsm_serial_tx
  import fsm_tx_pkg::*;
#(
  parameter int WIDTH      = c_width_def,
  parameter int GAP_CYCLES = c_gap_cycles_def
) (
  input  logic               clk,
  input  logic               rst,
  fsm_serial_tx_if.slave     bus
);

  localparam int               CNT_W      = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] c_bit_last = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_gap_last = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_tc;
  logic [CNT_W-1:0] cnt_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  assign cnt_last = (state_q == ST_GAP) ? c_gap_last : c_bit_last;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.data_valid) begin
          state_d  = ST_SHIFT;
          shreg_d  = bus.data_in;
          cnt_load = 1'b1;
        end
      end
      ST_SHIFT: begin
        cnt_en  = 1'b1;
        shreg_d = shreg_q << 1;
        if (cnt_tc) begin
          cnt_load = 1'b1;
          shreg_d  = '0;
          state_d  = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          cnt_load = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fsm_tx_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .last_i (cnt_last),
    .tc_o   (cnt_tc)
  );

  // Outputs decode registered state only, so inputs never reach them combinationally.
  assign bus.data_ready = (state_q == ST_IDLE);
  assign bus.dout_valid = (state_q == ST_SHIFT);
  assign bus.dout       = (state_q == ST_SHIFT) & shreg_q[WIDTH-1];
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_SHIFT) & cnt_tc;

endmodule

`default_nettype wire
